// File: rtl/ppu_scroll_if.sv
// CPU-side register bus into the PPU scroll/address block: register writes,
// the PPUSTATUS read pulse and PPUDATA access completion.
interface ppu_scroll_if;
   logic       reg_wr;
   logic [2:0] reg_sel;
   logic [7:0] reg_din;
   logic       status_rd;
   logic       data_acc;
   logic       inc32;

   modport master (
      output reg_wr, reg_sel, reg_din, status_rd, data_acc, inc32
   );

   modport slave (
      input reg_wr, reg_sel, reg_din, status_rd, data_acc, inc32
   );
endinterface

// File: rtl/ppu_scroll.sv
// PPU loopy scroll registers (v, t, fine_x, w), VRAM address mux and
// attribute quadrant selection for the render pipeline.
module ppu_scroll (
   input  logic         clk,
   input  logic         rst,
   ppu_scroll_if.slave  cpu,
   input  logic         rendering,
   input  logic         v_incx,
   input  logic         v_incy,
   input  logic         v_resetx,
   input  logic         v_resety,
   input  logic         fetch_tile,
   input  logic         fetch_attr,
   input  logic         fetch_chr,
   input  logic [12:0]  pattern_idx,
   input  logic [7:0]   vram_din,
   output logic [13:0]  vram_addr,
   output logic [2:0]   fine_x,
   output logic [2:0]   fine_y,
   output logic [1:0]   attr_o
);

   logic [14:0] v, t;
   logic        w;
   logic [1:0]  q;

   logic [14:0] v_next, t_next;
   logic [2:0]  fine_x_next;
   logic        w_next;
   logic        addr_load;
   logic        do_x, do_y;

   // CPU register writes update t/fine_x/w; a status read clears w after the write
   always_comb begin
      t_next      = t;
      fine_x_next = fine_x;
      w_next      = w;
      addr_load   = 1'b0;
      if (cpu.reg_wr) begin
         case (cpu.reg_sel)
            3'd0: t_next[11:10] = cpu.reg_din[1:0];
            3'd5: begin
               if (!w) begin
                  t_next[4:0] = cpu.reg_din[7:3];
                  fine_x_next = cpu.reg_din[2:0];
                  w_next      = 1'b1;
               end else begin
                  t_next[14:12] = cpu.reg_din[2:0];
                  t_next[9:5]   = cpu.reg_din[7:3];
                  w_next        = 1'b0;
               end
            end
            3'd6: begin
               if (!w) begin
                  t_next[13:8] = cpu.reg_din[5:0];
                  t_next[14]   = 1'b0;
                  w_next       = 1'b1;
               end else begin
                  t_next[7:0] = cpu.reg_din;
                  w_next      = 1'b0;
                  addr_load   = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (cpu.status_rd)
         w_next = 1'b0;
   end

   assign do_x = v_incx | (cpu.data_acc & rendering);
   assign do_y = v_incy | (cpu.data_acc & rendering);

   // v: linear step outside rendering, scroll increments during it; reloads from t win
   always_comb begin
      v_next = v;
      if (cpu.data_acc && !rendering) begin
         v_next = v + (cpu.inc32 ? 15'd32 : 15'd1);
      end else begin
         if (do_x) begin
            if (v[4:0] == 5'd31) begin
               v_next[4:0] = 5'd0;
               v_next[10]  = ~v[10];
            end else begin
               v_next[4:0] = v[4:0] + 5'd1;
            end
         end
         if (do_y) begin
            if (v[14:12] != 3'd7) begin
               v_next[14:12] = v[14:12] + 3'd1;
            end else begin
               v_next[14:12] = 3'd0;
               case (v[9:5])
                  5'd29: begin
                     v_next[9:5] = 5'd0;
                     v_next[11]  = ~v[11];
                  end
                  5'd31:   v_next[9:5] = 5'd0;
                  default: v_next[9:5] = v[9:5] + 5'd1;
               endcase
            end
         end
      end
      if (v_resetx) begin
         v_next[4:0] = t[4:0];
         v_next[10]  = t[10];
      end
      if (v_resety) begin
         v_next[14:11] = t[14:11];
         v_next[9:5]   = t[9:5];
      end
      if (addr_load)
         v_next = t_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v      <= 15'd0;
         t      <= 15'd0;
         fine_x <= 3'd0;
         w      <= 1'b0;
         q      <= 2'd0;
      end else begin
         v      <= v_next;
         t      <= t_next;
         fine_x <= fine_x_next;
         w      <= w_next;
         if (fetch_attr)
            q <= {v[6], v[1]};
      end
   end

   always_comb begin
      if (fetch_chr)
         vram_addr = {1'b0, pattern_idx};
      else if (fetch_attr)
         vram_addr = {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]};
      else if (fetch_tile)
         vram_addr = {2'b10, v[11:0]};
      else
         vram_addr = v[13:0];
   end

   always_comb begin
      case (q)
         2'd0:    attr_o = vram_din[1:0];
         2'd1:    attr_o = vram_din[3:2];
         2'd2:    attr_o = vram_din[5:4];
         default: attr_o = vram_din[7:6];
      endcase
   end

   assign fine_y = v[14:12];

endmodule

// File: tb/tb_ppu_scroll.sv
// Directed and randomized bench for ppu_scroll against a field-level
// behavioural model of the scroll registers.
module tb_ppu_scroll;

   logic        clk;
   logic        rst;
   logic        rendering;
   logic        v_incx, v_incy, v_resetx, v_resety;
   logic        fetch_tile, fetch_attr, fetch_chr;
   logic [12:0] pattern_idx;
   logic [7:0]  vram_din;
   logic [13:0] vram_addr;
   logic [2:0]  fine_x, fine_y;
   logic [1:0]  attr_o;

   ppu_scroll_if cpu ();

   ppu_scroll dut (
      .clk         (clk),
      .rst         (rst),
      .cpu         (cpu.slave),
      .rendering   (rendering),
      .v_incx      (v_incx),
      .v_incy      (v_incy),
      .v_resetx    (v_resetx),
      .v_resety    (v_resety),
      .fetch_tile  (fetch_tile),
      .fetch_attr  (fetch_attr),
      .fetch_chr   (fetch_chr),
      .pattern_idx (pattern_idx),
      .vram_din    (vram_din),
      .vram_addr   (vram_addr),
      .fine_x      (fine_x),
      .fine_y      (fine_y),
      .attr_o      (attr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // model state and its pending next values
   int m_v, m_t, m_fx, m_w, m_q;
   int n_v, n_t, n_fx, n_w, n_q;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_addr();
      if (fetch_chr)
         return int'(pattern_idx);
      else if (fetch_attr)
         return 'h23C0 | (((m_v >> 10) & 3) << 10) | (((m_v >> 7) & 7) << 3) | ((m_v >> 2) & 7);
      else if (fetch_tile)
         return 'h2000 | (m_v & 'hFFF);
      else
         return m_v & 'h3FFF;
   endfunction

   task automatic check_output(input string tag);
      check_val({tag, ".addr"},   32'(vram_addr), 32'(model_addr()));
      check_val({tag, ".fine_x"}, 32'(fine_x),    32'(m_fx));
      check_val({tag, ".fine_y"}, 32'(fine_y),    32'((m_v >> 12) & 7));
      check_val({tag, ".attr"},   32'(attr_o),    32'((int'(vram_din) >> (2 * m_q)) & 3));
   endtask

   // scroll behaviour decomposed into named fields rather than bit slices
   task automatic model_step();
      int din, cx, cy, nh, nvt, fy;
      bit addr_load;
      din = int'(cpu.reg_din);
      n_t = m_t; n_fx = m_fx; n_w = m_w; n_q = m_q; n_v = m_v;
      addr_load = 0;
      if (rst) begin
         n_v = 0; n_t = 0; n_fx = 0; n_w = 0; n_q = 0;
         return;
      end
      if (cpu.reg_wr) begin
         if (cpu.reg_sel == 3'd0) begin
            n_t = (n_t & ~('h3 << 10)) | ((din & 3) << 10);
         end else if (cpu.reg_sel == 3'd5) begin
            if (m_w == 0) begin
               n_t = (n_t & ~'h1F) | (din >> 3);
               n_fx = din & 7;
               n_w = 1;
            end else begin
               n_t = (n_t & ~('h7 << 12) & ~('h1F << 5)) | ((din & 7) << 12) | ((din >> 3) << 5);
               n_w = 0;
            end
         end else if (cpu.reg_sel == 3'd6) begin
            if (m_w == 0) begin
               n_t = (n_t & 'hFF) | ((din & 'h3F) << 8);
               n_w = 1;
            end else begin
               n_t = (n_t & ~'hFF) | din;
               n_w = 0;
               addr_load = 1;
            end
         end
      end
      if (cpu.status_rd) n_w = 0;
      if (cpu.data_acc && !rendering) begin
         n_v = (m_v + (cpu.inc32 ? 32 : 1)) % 32768;
      end else begin
         cx = m_v % 32; cy = (m_v / 32) % 32; nh = (m_v / 1024) % 2;
         nvt = (m_v / 2048) % 2; fy = m_v / 4096;
         if (v_incx || cpu.data_acc) begin
            if (cx == 31) begin cx = 0; nh = 1 - nh; end
            else cx = cx + 1;
         end
         if (v_incy || cpu.data_acc) begin
            if (fy < 7) fy = fy + 1;
            else begin
               fy = 0;
               if (cy == 29) begin cy = 0; nvt = 1 - nvt; end
               else if (cy == 31) cy = 0;
               else cy = cy + 1;
            end
         end
         n_v = fy * 4096 + nvt * 2048 + nh * 1024 + cy * 32 + cx;
      end
      if (v_resetx) n_v = (n_v & ~'h041F) | (m_t & 'h041F);
      if (v_resety) n_v = (n_v & ~'h7BE0) | (m_t & 'h7BE0);
      if (addr_load) n_v = n_t;
      if (fetch_attr) n_q = ((m_v >> 6) & 1) * 2 + ((m_v >> 1) & 1);
   endtask

   task automatic clear_pulses();
      rst = 1'b0;
      cpu.reg_wr = 1'b0; cpu.status_rd = 1'b0; cpu.data_acc = 1'b0;
      v_incx = 1'b0; v_incy = 1'b0; v_resetx = 1'b0; v_resety = 1'b0;
      fetch_tile = 1'b0; fetch_attr = 1'b0; fetch_chr = 1'b0;
   endtask

   task automatic apply_stimulus(input string tag);
      model_step();
      @(posedge clk);
      #1;
      m_v = n_v; m_t = n_t; m_fx = n_fx; m_w = n_w; m_q = n_q;
      clear_pulses();
      #1;
      check_output(tag);
   endtask

   task automatic write_reg(input logic [2:0] sel, input logic [7:0] din, input string tag);
      cpu.reg_wr = 1'b1; cpu.reg_sel = sel; cpu.reg_din = din;
      apply_stimulus(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      apply_stimulus("reset");
   endtask

   function automatic logic [31:0] dut_v();
      return {17'd0, fine_y[2], vram_addr};
   endfunction

   initial begin
      m_v = 0; m_t = 0; m_fx = 0; m_w = 0; m_q = 0;
      clear_pulses();
      cpu.reg_sel = 3'd0; cpu.reg_din = 8'd0; cpu.inc32 = 1'b0;
      rendering = 1'b0; pattern_idx = 13'd0; vram_din = 8'd0;
      #2;

      do_reset();
      check_val("reset_addr", 32'(vram_addr), 32'h0);
      check_val("reset_fine_x", 32'(fine_x), 32'h0);

      // PPUADDR pair then +32 data access
      write_reg(3'd6, 8'h21, "addr_hi");
      write_reg(3'd6, 8'h08, "addr_lo");
      check_val("addr_pair", dut_v(), 32'h2108);
      cpu.inc32 = 1'b1; cpu.data_acc = 1'b1;
      apply_stimulus("inc32");
      check_val("inc32_v", dut_v(), 32'h2128);
      cpu.inc32 = 1'b0;

      do_reset();
      write_reg(3'd5, 8'h7D, "scroll_x");
      check_val("scroll_fine_x", 32'(fine_x), 32'h5);
      write_reg(3'd5, 8'h5E, "scroll_y");
      v_resetx = 1'b1; v_resety = 1'b1;
      apply_stimulus("reload");
      check_val("reload_v", dut_v(), 32'h616F);

      // fine Y 7 / coarse Y 29 wraps and toggles the vertical nametable
      do_reset();
      write_reg(3'd5, 8'h00, "sx0");
      write_reg(3'd5, 8'hEF, "sy29");
      v_resety = 1'b1;
      apply_stimulus("resety29");
      check_val("v_73a0", dut_v(), 32'h73A0);
      v_incy = 1'b1;
      apply_stimulus("incy29");
      check_val("incy29_v", dut_v(), 32'h0800);
      write_reg(3'd5, 8'h00, "sx0b");
      write_reg(3'd5, 8'hFF, "sy31");
      v_resety = 1'b1;
      apply_stimulus("resety31");
      check_val("v_73e0", dut_v(), 32'h73E0);
      v_incy = 1'b1;
      apply_stimulus("incy31");
      check_val("incy31_v", dut_v(), 32'h0000);

      do_reset();
      write_reg(3'd6, 8'h00, "a001f_hi");
      write_reg(3'd6, 8'h1F, "a001f_lo");
      v_incx = 1'b1; v_incy = 1'b1;
      apply_stimulus("incxy");
      check_val("incxy_v", dut_v(), 32'h1400);
      write_reg(3'd6, 8'h08, "a0842_hi");
      write_reg(3'd6, 8'h42, "a0842_lo");
      fetch_attr = 1'b1;
      #1;
      check_val("attr_addr", 32'(vram_addr), 32'h2BC0);
      apply_stimulus("attr_fetch");
      vram_din = 8'hE4;
      #1;
      check_val("attr_o", 32'(attr_o), 32'h3);
      check_output("attr_next");

      // status read discards a half-written address; reset does likewise
      do_reset();
      write_reg(3'd6, 8'h3F, "half_hi");
      cpu.status_rd = 1'b1;
      apply_stimulus("status");
      write_reg(3'd6, 8'h00, "full_hi");
      write_reg(3'd6, 8'h10, "full_lo");
      check_val("status_v", dut_v(), 32'h0010);
      do_reset();
      write_reg(3'd6, 8'h3F, "rst_hi");
      do_reset();
      write_reg(3'd6, 8'h12, "after_rst");
      check_val("after_rst_v", dut_v(), 32'h0000);
      write_reg(3'd6, 8'h34, "after_rst_lo");
      check_val("after_rst_pair", dut_v(), 32'h1234);

      fetch_chr = 1'b1; fetch_tile = 1'b1; pattern_idx = 13'h1ABC;
      #1;
      check_val("chr_priority", 32'(vram_addr), 32'h1ABC);
      apply_stimulus("chr_step");

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         int pick;
         rst = ($urandom_range(0, 31) == 0);
         cpu.reg_wr = ($urandom_range(0, 2) == 0);
         pick = $urandom_range(0, 3);
         cpu.reg_sel = (pick == 0) ? 3'd0 : (pick == 1) ? 3'd5 : (pick == 2) ? 3'd6 : 3'($urandom_range(0, 7));
         cpu.reg_din = 8'($urandom);
         cpu.status_rd = ($urandom_range(0, 7) == 0);
         cpu.data_acc = ($urandom_range(0, 7) == 0);
         cpu.inc32 = 1'($urandom);
         rendering = 1'($urandom);
         v_incx = ($urandom_range(0, 3) == 0);
         v_incy = ($urandom_range(0, 3) == 0);
         v_resetx = ($urandom_range(0, 7) == 0);
         v_resety = ($urandom_range(0, 7) == 0);
         fetch_chr = ($urandom_range(0, 3) == 0);
         fetch_attr = ($urandom_range(0, 2) == 0);
         fetch_tile = ($urandom_range(0, 2) == 0);
         pattern_idx = 13'($urandom);
         vram_din = 8'($urandom);
         #1;
         check_val("rand_comb_addr", 32'(vram_addr), 32'(model_addr()));
         apply_stimulus("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
